// File: rtl/sms_pkg.sv
// Shared types, default field parameters and the linear-map helper for the power-map S-box engine.
package sms_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sms_state_e;

    localparam int SMS_DEF_WIDTH = 6;
    localparam logic [SMS_DEF_WIDTH:0] SMS_DEF_POLY = 7'b1000011;

    // Maps are evaluated on zero-padded operands so one function serves every WIDTH up to MAP_MAX_W.
    localparam int MAP_MAX_W = 16;
    localparam int MAP_MAT_W = MAP_MAX_W * MAP_MAX_W + MAP_MAX_W;

    // Row i of an n*n matrix sits at m[i*n +: n]; bits above n in the slice hit zeros of v.
    function automatic logic [MAP_MAX_W-1:0] lin_map(
        input logic [MAP_MAT_W-1:0] m,
        input logic [MAP_MAX_W-1:0] v,
        input int                   n
    );
        logic [MAP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAP_MAX_W; i++) begin
            if (i < n) begin
                r[i] = ^(m[i*n +: MAP_MAX_W] & v);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sms_power_engine_if.sv
// Valid/ready operand and result channels of the power-map engine.
interface sms_power_engine_if
    import sms_pkg::*;
#(
    parameter int WIDTH = SMS_DEF_WIDTH,
    parameter int EXP_W = WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;

    modport master (
        output in_valid, in_x, in_exp, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_x, in_exp, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/gf2n_mul.sv
// Combinational GF(2^WIDTH) multiply, polynomial basis, reduced modulo POLY.
module gf2n_mul
    import sms_pkg::*;
#(
    parameter int               WIDTH = SMS_DEF_WIDTH,
    parameter logic [WIDTH:0]   POLY  = SMS_DEF_POLY
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] a_shift;

    // Shift-and-add with reduction folded into every shift, so nothing ever exceeds WIDTH bits.
    always_comb begin
        p       = '0;
        a_shift = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) begin
                p = p ^ a_shift;
            end
            a_shift = {a_shift[WIDTH-2:0], 1'b0} ^ (a_shift[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
        end
    end

endmodule

// File: rtl/sms_power_engine.sv
// Iterative power-map engine y = x^e over GF(2^WIDTH), one exponent bit per cycle, MSB first.
// Optional basis-change wrapper on input and output enabled by SMS_LINEAR_MAP_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// RUN   | square-and-multiply on e[cnt], cnt counting down to 0
// DONE  | result presented on out_y, waiting for out_ready
module sms_power_engine
    import sms_pkg::*;
#(
    parameter int                     WIDTH   = SMS_DEF_WIDTH,
    parameter logic [WIDTH:0]         POLY    = SMS_DEF_POLY,
    parameter int                     EXP_W   = WIDTH,
    parameter logic [WIDTH*WIDTH-1:0] IN_MAP  = (WIDTH*WIDTH)'({WIDTH{{WIDTH{1'b0}}, 1'b1}}),
    parameter logic [WIDTH*WIDTH-1:0] OUT_MAP = (WIDTH*WIDTH)'({WIDTH{{WIDTH{1'b0}}, 1'b1}})
) (
    input  logic             clk,
    input  logic             rst,
    sms_power_engine_if.slave bus
);

    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    if (WIDTH < 2 || WIDTH > MAP_MAX_W || $bits(IN_MAP) != $bits(OUT_MAP)) begin : g_bad_cfg
        $error("sms_power_engine: WIDTH must be in 2..%0d", MAP_MAX_W);
    end

    sms_state_e       state_q;
    sms_state_e       state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] x_q;
    logic [EXP_W-1:0] exp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] out_y_q;

    logic [WIDTH-1:0] acc_sq;
    logic [WIDTH-1:0] acc_sq_x;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] x_load;
    logic [WIDTH-1:0] y_load;
    logic             accept;
    logic             last_bit;

    gf2n_mul #(.WIDTH(WIDTH), .POLY(POLY)) u_square (
        .a (acc_q),
        .b (acc_q),
        .p (acc_sq)
    );

    gf2n_mul #(.WIDTH(WIDTH), .POLY(POLY)) u_times_x (
        .a (acc_sq),
        .b (x_q),
        .p (acc_sq_x)
    );

    assign acc_next = exp_q[cnt_q] ? acc_sq_x : acc_sq;
    assign last_bit = (cnt_q == '0);

`ifdef SMS_LINEAR_MAP_EN
    localparam logic [MAP_MAT_W-1:0] IN_MAP_EXT  = MAP_MAT_W'(IN_MAP);
    localparam logic [MAP_MAT_W-1:0] OUT_MAP_EXT = MAP_MAT_W'(OUT_MAP);

    assign x_load = WIDTH'(lin_map(IN_MAP_EXT, MAP_MAX_W'(bus.in_x), WIDTH));
    assign y_load = WIDTH'(lin_map(OUT_MAP_EXT, MAP_MAX_W'(acc_next), WIDTH));
`else
    assign x_load = bus.in_x;
    assign y_load = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latency is fixed at EXP_W cycles: leading zero bits of e still run, they just square 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            x_q     <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            out_y_q <= '0;
        end else if (accept) begin
            x_q   <= x_load;
            exp_q <= bus.in_exp;
            acc_q <= WIDTH'(1);
            cnt_q <= CNT_W'(EXP_W - 1);
        end else if (state_q == RUN) begin
            acc_q <= acc_next;
            if (last_bit) begin
                out_y_q <= y_load;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.out_y = out_y_q;

endmodule
